// File: rtl/stack_seq.sv
// PUSH/POP sequencer: moves a 16-bit register pair through the stack a byte at a
// time, driving the regfile control ports and an 8-bit request/ack memory bus.
module stack_seq #(
  parameter int SP_IDX   = 3,
  parameter int MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [2:0]  rr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  regfile_rn_in,
  output logic [4:0]  regfile_rn_out,
  output logic        regfile_we,
  output logic        regfile_change16,
  output logic        regfile_inc,
  output logic [7:0]  regfile_data_in,
  input  logic [15:0] regfile_data_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [4:0] {
    IDLE,
    P_DEC1, P_ADDR1, P_DATA1, P_WR1,
    P_DEC2, P_ADDR2, P_DATA2, P_WR2,
    O_ADDR1, O_RD1, O_WR1, O_INC1,
    O_ADDR2, O_RD2, O_WR2, O_INC2,
    DONE, ABORT
  } state_t;

  localparam logic [4:0] SP_RN  = {2'b10, 3'(SP_IDX)};
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  state_t      state, nxt;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic [7:0]  wait_cnt;
  logic [2:0]  rr_q;
  logic        rr_legal;
  logic        bus_state;
  logic        timeout;

  assign rr_legal  = (rr == 3'd0) || (rr == 3'd1) || (rr == 3'd2) || (rr == 3'd4);
  assign bus_state = (state == P_WR1) || (state == P_WR2) ||
                     (state == O_RD1) || (state == O_RD2);
  assign timeout   = (wait_cnt == WAIT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      wait_cnt <= '0;
      rr_q     <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) rr_q <= rr;
      if (state == P_ADDR1 || state == P_ADDR2 || state == O_ADDR1 || state == O_ADDR2)
        addr_q <= regfile_data_out;
      if (state == P_DATA1 || state == P_DATA2)
        data_q <= regfile_data_out[7:0];
      if ((state == O_RD1 || state == O_RD2) && mem_ack)
        data_q <= mem_rdata;
      // Non-bus states hold the counter at zero, so it is clear on entry to a bus state.
      if (bus_state && !mem_ack) wait_cnt <= wait_cnt + 8'd1;
      else                       wait_cnt <= '0;
    end
  end

  always_comb begin
    nxt              = state;
    busy             = (state != IDLE);
    done             = 1'b0;
    err              = 1'b0;
    regfile_rn_in    = '0;
    regfile_rn_out   = '0;
    regfile_we       = 1'b0;
    regfile_change16 = 1'b0;
    regfile_inc      = 1'b0;
    regfile_data_in  = '0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    case (state)
      IDLE: if (start) nxt = !rr_legal ? ABORT : (op ? O_ADDR1 : P_DEC1);
      P_DEC1, P_DEC2: begin
        regfile_we       = 1'b1;
        regfile_rn_in    = SP_RN;
        regfile_change16 = 1'b1;
        nxt = (state == P_DEC1) ? P_ADDR1 : P_ADDR2;
      end
      P_ADDR1: begin regfile_rn_out = SP_RN;          nxt = P_DATA1; end
      P_DATA1: begin regfile_rn_out = {2'b01, rr_q};  nxt = P_WR1;   end
      P_ADDR2: begin regfile_rn_out = SP_RN;          nxt = P_DATA2; end
      P_DATA2: begin regfile_rn_out = {2'b00, rr_q};  nxt = P_WR2;   end
      P_WR1, P_WR2: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        if (mem_ack)      nxt = (state == P_WR1) ? P_DEC2 : DONE;
        else if (timeout) nxt = ABORT;
      end
      O_ADDR1: begin regfile_rn_out = SP_RN; nxt = O_RD1; end
      O_ADDR2: begin regfile_rn_out = SP_RN; nxt = O_RD2; end
      O_RD1, O_RD2: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack)      nxt = (state == O_RD1) ? O_WR1 : O_WR2;
        else if (timeout) nxt = ABORT;
      end
      // Pop fills the low byte first because it sits at the lower stack address.
      O_WR1: begin
        regfile_we      = 1'b1;
        regfile_rn_in   = {2'b00, rr_q};
        regfile_data_in = data_q;
        nxt = O_INC1;
      end
      O_WR2: begin
        regfile_we      = 1'b1;
        regfile_rn_in   = {2'b01, rr_q};
        regfile_data_in = data_q;
        nxt = O_INC2;
      end
      O_INC1, O_INC2: begin
        regfile_we       = 1'b1;
        regfile_rn_in    = SP_RN;
        regfile_change16 = 1'b1;
        regfile_inc      = 1'b1;
        nxt = (state == O_INC1) ? O_ADDR2 : DONE;
      end
      DONE:  begin done = 1'b1; nxt = IDLE; end
      ABORT: begin err  = 1'b1; nxt = IDLE; end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: regfile and memory models around the DUT, a
// write scoreboard, and immediate-assertion checks on latency and final state.
module tb_stack_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [2:0]  rr = '0;
  logic        busy, done, err;
  logic [4:0]  regfile_rn_in, regfile_rn_out;
  logic        regfile_we, regfile_change16, regfile_inc;
  logic [7:0]  regfile_data_in;
  logic [15:0] regfile_data_out;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;

  stack_seq #(.SP_IDX(3), .MAX_WAIT(4)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .rr(rr),
    .busy(busy), .done(done), .err(err),
    .regfile_rn_in(regfile_rn_in), .regfile_rn_out(regfile_rn_out),
    .regfile_we(regfile_we), .regfile_change16(regfile_change16),
    .regfile_inc(regfile_inc), .regfile_data_in(regfile_data_in),
    .regfile_data_out(regfile_data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  // Register file model: 16-bit read when F is set, otherwise the byte chosen by H in [7:0].
  logic [15:0] rf [8];
  logic        set_en = 1'b0;
  logic [2:0]  set_idx = '0;
  logic [15:0] set_val = '0;
  wire  [15:0] rf_sel = rf[regfile_rn_out[2:0]];
  assign regfile_data_out = regfile_rn_out[4] ? rf_sel :
                            regfile_rn_out[3] ? {8'h00, rf_sel[15:8]} : {8'h00, rf_sel[7:0]};

  always @(posedge clock) begin
    if (set_en) rf[set_idx] <= set_val;
    else if (regfile_we) begin
      if (regfile_change16)
        rf[regfile_rn_in[2:0]] <= regfile_inc ? rf[regfile_rn_in[2:0]] + 16'd1
                                              : rf[regfile_rn_in[2:0]] - 16'd1;
      else if (regfile_rn_in[3]) rf[regfile_rn_in[2:0]][15:8] <= regfile_data_in;
      else                       rf[regfile_rn_in[2:0]][7:0]  <= regfile_data_in;
    end
  end

  // Memory model: ack after ack_dly waiting cycles, never when ack_en is low.
  logic [7:0] mem [0:65535];
  logic       ack_en = 1'b1;
  int         ack_dly = 0;
  int         req_cnt = 0;
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && ack_en && (req_cnt >= ack_dly);
  always @(posedge clock) req_cnt <= (mem_req && !mem_ack) ? req_cnt + 1 : 0;

  // Monitor: records acked writes, counts pulses, and flags bus changes while waiting.
  logic [23:0] obs [$];
  int done_cnt = 0, we_cnt = 0, unstable = 0;
  logic        prev_hold = 1'b0;
  logic [24:0] prev_bus = '0;
  always @(negedge clock) begin
    if (mem_req && mem_we && mem_ack) obs.push_back({mem_addr, mem_wdata});
    if (done) done_cnt++;
    if (regfile_we) we_cnt++;
    if (prev_hold && (!mem_req || {mem_we, mem_addr, mem_wdata} != prev_bus)) unstable++;
    prev_hold = mem_req && !mem_ack;
    prev_bus  = {mem_we, mem_addr, mem_wdata};
  end

  int n_chk = 0, n_fail = 0;
  logic [23:0] exp_q [$];
  int rd_ptr = 0;

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_writes(input string tag);
    logic [23:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (rd_ptr < obs.size()) ? obs[rd_ptr] : 24'hxxxxxx;
      rd_ptr++;
      check(tag, {40'h0, o}, {40'h0, e});
    end
    check({tag, "_count"}, 64'(obs.size()), 64'(rd_ptr));
  endtask

  task automatic set_reg(input logic [2:0] idx, input logic [15:0] val);
    @(negedge clock);
    set_en = 1'b1; set_idx = idx; set_val = val;
    @(negedge clock);
    set_en = 1'b0;
  endtask

  task automatic run_op(input logic o, input logic [2:0] r, input int restart_at,
                        output int lat, output logic saw_err);
    @(negedge clock);
    op = o; rr = r; start = 1'b1;
    lat = 0; saw_err = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clock);
      start = (k == restart_at);
      if (done || err) begin lat = k; saw_err = err; break; end
    end
    start = 1'b0;
  endtask

  function automatic logic [63:0] all_out();
    return {14'h0, busy, done, err, regfile_we, regfile_change16, regfile_inc,
            regfile_rn_in, regfile_rn_out, regfile_data_in,
            mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  initial begin
    int lat, d0, w0;
    logic e;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    repeat (2) @(negedge clock);
    check("reset_outputs", all_out(), 64'h0);
    reset = 1'b0;

    // Push BC with immediate ack
    set_reg(3, 16'hD000); set_reg(0, 16'h1234);
    exp_q.push_back({16'hCFFF, 8'h12}); exp_q.push_back({16'hCFFE, 8'h34});
    run_op(1'b0, 3'd0, 0, lat, e);
    check("push_latency", 64'(lat), 64'd9);
    check("push_err", {63'h0, e}, 64'h0);
    chk_writes("push_wr");
    check("push_sp", {48'h0, rf[3]}, 64'hCFFE);

    // Pop into PC
    mem[16'hCFFE] = 8'hCD; mem[16'hCFFF] = 8'hAB;
    run_op(1'b1, 3'd4, 0, lat, e);
    check("pop_latency", 64'(lat), 64'd9);
    check("pop_pc", {48'h0, rf[4]}, 64'hABCD);
    check("pop_sp", {48'h0, rf[3]}, 64'hD000);

    // Push HL with three wait cycles per request
    ack_dly = 3; w0 = unstable;
    set_reg(2, 16'hBEEF);
    exp_q.push_back({16'hCFFF, 8'hBE}); exp_q.push_back({16'hCFFE, 8'hEF});
    run_op(1'b0, 3'd2, 0, lat, e);
    check("wait_latency", 64'(lat), 64'd15);
    chk_writes("wait_wr");
    check("wait_sp", {48'h0, rf[3]}, 64'hCFFE);
    check("wait_bus_stable", 64'(unstable - w0), 64'h0);
    ack_dly = 0;

    // Pop DE with no ack ever: err five cycles after entering the read
    ack_en = 1'b0;
    set_reg(1, 16'h5566);
    run_op(1'b1, 3'd1, 0, lat, e);
    check("timeout_latency", 64'(lat), 64'd7);
    check("timeout_err", {63'h0, e}, 64'h1);
    @(negedge clock);
    check("timeout_busy", {63'h0, busy}, 64'h0);
    check("timeout_de", {48'h0, rf[1]}, 64'h5566);
    check("timeout_sp", {48'h0, rf[3]}, 64'hCFFE);
    ack_en = 1'b1;

    // Illegal pair index
    w0 = we_cnt;
    run_op(1'b0, 3'd3, 0, lat, e);
    check("illegal_latency", 64'(lat), 64'd1);
    check("illegal_err", {63'h0, e}, 64'h1);
    check("illegal_no_we", 64'(we_cnt - w0), 64'h0);
    chk_writes("illegal_wr");

    // Second start mid-push is ignored
    d0 = done_cnt;
    exp_q.push_back({16'hCFFD, 8'h12}); exp_q.push_back({16'hCFFC, 8'h34});
    run_op(1'b0, 3'd0, 3, lat, e);
    check("busy_latency", 64'(lat), 64'd9);
    repeat (12) @(negedge clock);
    check("busy_one_done", 64'(done_cnt - d0), 64'h1);
    chk_writes("busy_wr");
    check("busy_sp", {48'h0, rf[3]}, 64'hCFFC);

    // Reset while stuck in P_WR1
    ack_en = 1'b0;
    @(negedge clock);
    op = 1'b0; rr = 3'd1; start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (3) @(negedge clock);
    check("midop_in_wr", {63'h0, mem_req}, 64'h1);
    reset = 1'b1;
    @(negedge clock);
    check("midop_reset_outputs", all_out(), 64'h0);
    reset = 1'b0; ack_en = 1'b1;
    check("midop_sp_kept", {48'h0, rf[3]}, 64'hCFFB);

    // SP wrap from 0x0000
    set_reg(3, 16'h0000); set_reg(1, 16'h7788);
    exp_q.push_back({16'hFFFF, 8'h77}); exp_q.push_back({16'hFFFE, 8'h88});
    run_op(1'b0, 3'd1, 0, lat, e);
    check("wrap_latency", 64'(lat), 64'd9);
    chk_writes("wrap_wr");
    check("wrap_sp", {48'h0, rf[3]}, 64'hFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
